bfloat16_accumulator: RTL and testbench
=======================================

// Module: bfloat16_accumulator
// PURPOSE
//  Sits directly downstream of bfloat16_mult in the CNN datapath.
//  Sums a stream of bfloat16 products over one kernel window, then emits a single bfloat16 partial sum.
//  A window is one or more products terminated by in_last.
//  Valid/ready handshakes on both sides. Multi-cycle FSM adder: one product accepted at most every 4 cycles.
// PARAMETERS
//  GUARD_BITS  8   extra LSBs below the 7-bit fraction in the internal accumulator (range 3..16)
//  CNT_W       8   width of term counter; the count saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active low
//  in_data    in   16     bfloat16 product {sign, exp[7:0], frac[6:0]}
//  in_valid   in   1      in_data/in_last valid
//  in_last    in   1      in_data is the final term of the window
//  in_ready   out  1      accumulator can take a term
//  out_data   out  16     rounded bfloat16 window sum
//  out_count  out  CNT_W  number of terms summed in this window
//  out_valid  out  1      out_data/out_count valid
//  out_ready  in   1      consumer accepts the result
// BEHAVIOUR
//  Reset state: FSM=IDLE, accumulator=+0, count=0.
//   Reset values: in_ready=1, out_valid=0, out_data=16'h0000, out_count=0.
//  Asserting rst_n low at any time (including mid-add or while out_valid=1) aborts immediately.
//   The partial sum is discarded and no result is produced.
//  Internal accumulator: sign, 9-bit exponent (extra bit detects overflow), mantissa 1.(7+GUARD_BITS), sticky bit.
//  FSM states:
//   IDLE : in_ready=1. On in_valid, latch in_data and in_last, count+=1, go to ALIGN.
//   ALIGN: put the smaller-magnitude operand on the right. Shift it right by the exponent difference.
//          Bits shifted below the LSB OR into sticky. A difference >= 8+GUARD_BITS leaves only sticky.
//   ADD  : add or subtract the magnitudes per sign. The larger operand's sign is the result sign.
//          An exact zero result has sign + (1.0 + -1.0 = +0).
//   NORM : renormalise. Left-shift by leading zeros or right-shift by 1 on carry, adjusting the exponent.
//          Exponent <= 0 flushes to +0. Exponent >= 255 gives Inf and sets a sticky inf flag for the window.
//          Then: last latched -> ROUND, else -> IDLE.
//   ROUND: round to nearest, ties to even, at the 7-bit fraction. Guard = first dropped bit; sticky = OR of the rest.
//          A rounding carry increments the exponent. If that overflows, the result is Inf.
//          If the inf flag is set, out_data = {sign, 8'hFF, 7'h0}.
//          Register out_data and out_count, then go to OUT.
//   OUT  : out_valid=1, in_ready=0. out_data and out_count are held stable until out_valid & out_ready.
//          On that handshake: clear accumulator, count and inf flag; go to IDLE (in_ready=1 next cycle).
//  in_ready is 1 only in IDLE. in_valid with in_ready=0 is ignored; the upstream holds the data.
//  Timing: term accepted at edge N -> back in IDLE at N+3, so accepts are spaced at least 4 cycles apart.
//   For a last term: out_valid is asserted from edge N+4.
//  Input handling:
//   Input exp==0 is treated as zero (denormals flushed).
//   Input exp==8'hFF is treated as Inf: it sets the inf flag and carries its sign.
//   Sign with the inf flag: the first Inf seen takes precedence; NaN is not supported.
//  A single-term window passes the term through unchanged, except that a denormal becomes +0.
//  out_count saturates at all-ones and never wraps.
// TESTING
//  Check out_count in every scenario.
//  1. Two-term sum: 16'h3F80 (1.0), then 16'h4000 (2.0) with last -> out_data=16'h4040, out_count=2.
//  2. Cancellation: 16'h3F80, then 16'hBF80 with last -> out_data=16'h0000 (+0).
//     Repeat with the order reversed -> also 16'h0000.
//  3. Overflow: 16'h7F7F, then 16'h7F7F with last -> out_data=16'h7F80 (+Inf).
//     The next window of 16'h3F80 alone -> 16'h3F80 (inf flag cleared).
//  4. Rounding tie: 16'h3F80 + 16'h3B80 (2^-8) with last -> 16'h3F80 (tie, even kept).
//     16'h3F81 + 16'h3B80 -> 16'h3F82 (tie rounds up to even).
//  5. Backpressure: complete a window while out_ready=0 for 6 cycles.
//     -> out_valid held, out_data stable, in_ready=0 throughout.
//     Then out_ready=1 for 1 cycle -> out_valid drops, in_ready=1 next cycle.
//  6. Reset mid-window: 3 terms accepted, no last; pulse rst_n low 1 cycle asynchronously mid-ALIGN.
//     -> in_ready=1, out_valid=0. A new window of 16'h4000 alone -> 16'h4000, out_count=1.

Source files
------------

// File: rtl/bfloat16_accumulator.sv
// bfloat16 window accumulator: sums a stream of bfloat16 products terminated by
// in_last and emits one rounded bfloat16 partial sum with its term count.
// A small multi-cycle FSM (ALIGN / ADD / NORM / ROUND) does one addition per term.
module bfloat16_accumulator #(
  parameter int GUARD_BITS = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  // Mantissa is 1.(7+GUARD_BITS); the extended form appends one sticky bit.
  localparam int MW = 8 + GUARD_BITS;
  localparam int EW = MW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
  } state_t;

  state_t state_q, state_d;

  // Accumulator (zero is encoded as exponent 0, mantissa 0)
  logic          acc_sign_q;
  logic [8:0]    acc_exp_q;
  logic [MW-1:0] acc_mant_q;
  logic          acc_sticky_q;
  // Latched input term
  logic          op_sign_q;
  logic [7:0]    op_exp_q;
  logic [6:0]    op_frac_q;
  logic          last_q;
  // Window-level infinity flag; the first Inf seen owns the sign
  logic          inf_q;
  logic          inf_sign_q;
  logic [CNT_W-1:0] cnt_q;
  // Aligned operands
  logic          big_sign_q, small_sign_q;
  logic [8:0]    big_exp_q;
  logic [EW-1:0] big_ext_q, small_ext_q;
  // Raw sum
  logic [EW:0]   sum_q;
  logic          sum_sign_q;
  logic [8:0]    sum_exp_q;
  // Result
  logic [15:0]      out_data_q;
  logic [CNT_W-1:0] out_count_q;

  // Combinational next values
  logic          op_zero, op_inf;
  logic [8:0]    op_exp9, small_exp;
  logic [EW-1:0] op_ext, acc_ext, small_ext;
  logic          big_sign_d, small_sign_d;
  logic [8:0]    big_exp_d;
  logic [EW-1:0] big_ext_d, small_ext_d;
  logic [EW:0]   sum_d;
  logic          sum_sign_d;
  logic [5:0]    lz;
  logic [EW-1:0] norm_ext_d;
  logic signed [10:0] norm_exp_d;
  logic          norm_zero_d, norm_ovf_d;

  // Shift right by d, folding every bit that falls off into the LSB (sticky).
  function automatic logic [EW-1:0] align_shift(input logic [EW-1:0] v, input logic [8:0] d);
    logic [EW-1:0] shifted;
    logic [EW-1:0] lost_mask;
    shifted   = v >> d;
    lost_mask = ~({EW{1'b1}} << d);
    if (d >= 9'(MW)) align_shift = {{(EW-1){1'b0}}, |v};
    else             align_shift = {shifted[EW-1:1], shifted[0] | (|(v & lost_mask))};
  endfunction

  // Leading-zero count of the extended mantissa.
  function automatic logic [5:0] lzc(input logic [EW-1:0] v);
    logic found;
    found = 1'b0;
    lzc   = 6'(EW);
    for (int i = EW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        lzc   = 6'(EW - 1 - i);
        found = 1'b1;
      end
    end
  endfunction

  // Round to nearest even at the 7-bit fraction; a carry ripples into the exponent.
  function automatic logic [15:0] round_bf16(input logic s, input logic [8:0] e,
                                             input logic [MW-1:0] m, input logic st);
    logic        lsb, grd, rest, up;
    logic [15:0] v;
    lsb  = m[GUARD_BITS];
    grd  = m[GUARD_BITS-1];
    rest = (|m[GUARD_BITS-2:0]) | st;
    up   = grd & (rest | lsb);
    v    = {e, m[MW-2:GUARD_BITS]} + {15'd0, up};
    if (e == 9'd0 || !m[MW-1]) round_bf16 = 16'h0000;
    else if (v[15:7] >= 9'd255) round_bf16 = {s, 8'hFF, 7'h00};
    else                        round_bf16 = {s, v[14:0]};
  endfunction

  // Term counter that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ALIGN: order operands by magnitude and shift the smaller one
  always_comb begin
    op_zero = (op_exp_q == 8'h00);
    op_inf  = (op_exp_q == 8'hFF);
    op_exp9 = op_zero ? 9'd0 : {1'b0, op_exp_q};
    op_ext  = op_zero ? '0 : {1'b1, op_frac_q, {GUARD_BITS{1'b0}}, 1'b0};
    acc_ext = {acc_mant_q, acc_sticky_q};
    if ({acc_exp_q, acc_ext} >= {op_exp9, op_ext}) begin
      big_sign_d   = acc_sign_q;
      big_exp_d    = acc_exp_q;
      big_ext_d    = acc_ext;
      small_sign_d = op_sign_q;
      small_exp    = op_exp9;
      small_ext    = op_ext;
    end else begin
      big_sign_d   = op_sign_q;
      big_exp_d    = op_exp9;
      big_ext_d    = op_ext;
      small_sign_d = acc_sign_q;
      small_exp    = acc_exp_q;
      small_ext    = acc_ext;
    end
    small_ext_d = align_shift(small_ext, big_exp_d - small_exp);
  end

  // ADD: magnitude add/subtract; an exact zero is always +0
  always_comb begin
    if (big_sign_q ^ small_sign_q) sum_d = {1'b0, big_ext_q} - {1'b0, small_ext_q};
    else                           sum_d = {1'b0, big_ext_q} + {1'b0, small_ext_q};
    sum_sign_d = (sum_d == '0) ? 1'b0 : big_sign_q;
  end

  // NORM: renormalise the raw sum and classify underflow / overflow
  always_comb begin
    lz = lzc(sum_q[EW-1:0]);
    if (sum_q[EW]) begin
      norm_ext_d = {sum_q[EW:2], sum_q[1] | sum_q[0]};
      norm_exp_d = $signed({2'b00, sum_exp_q}) + 11'sd1;
    end else begin
      norm_ext_d = sum_q[EW-1:0] << lz;
      norm_exp_d = $signed({2'b00, sum_exp_q}) - $signed({5'b00000, lz});
    end
    norm_zero_d = (sum_q == '0) || (norm_exp_d <= 11'sd0);
    norm_ovf_d  = (sum_q != '0) && (norm_exp_d >= 11'sd255);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = last_q ? S_ROUND : S_IDLE;
      S_ROUND: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    out_data  = out_data_q;
    out_count = out_count_q;
  end

  // Datapath registers, advanced by the state the FSM is leaving
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sign_q   <= 1'b0;
      acc_exp_q    <= '0;
      acc_mant_q   <= '0;
      acc_sticky_q <= 1'b0;
      op_sign_q    <= 1'b0;
      op_exp_q     <= '0;
      op_frac_q    <= '0;
      last_q       <= 1'b0;
      inf_q        <= 1'b0;
      inf_sign_q   <= 1'b0;
      cnt_q        <= '0;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      big_exp_q    <= '0;
      big_ext_q    <= '0;
      small_ext_q  <= '0;
      sum_q        <= '0;
      sum_sign_q   <= 1'b0;
      sum_exp_q    <= '0;
      out_data_q   <= 16'h0000;
      out_count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_sign_q <= in_data[15];
            op_exp_q  <= in_data[14:7];
            op_frac_q <= in_data[6:0];
            last_q    <= in_last;
            cnt_q     <= sat_inc(cnt_q);
          end
        end
        S_ALIGN: begin
          big_sign_q   <= big_sign_d;
          small_sign_q <= small_sign_d;
          big_exp_q    <= big_exp_d;
          big_ext_q    <= big_ext_d;
          small_ext_q  <= small_ext_d;
          if (op_inf && !inf_q) begin
            inf_q      <= 1'b1;
            inf_sign_q <= op_sign_q;
          end
        end
        S_ADD: begin
          sum_q      <= sum_d;
          sum_sign_q <= sum_sign_d;
          sum_exp_q  <= big_exp_q;
        end
        S_NORM: begin
          if (norm_ovf_d || norm_zero_d) begin
            acc_sign_q   <= 1'b0;
            acc_exp_q    <= '0;
            acc_mant_q   <= '0;
            acc_sticky_q <= 1'b0;
          end else begin
            acc_sign_q   <= sum_sign_q;
            acc_exp_q    <= norm_exp_d[8:0];
            acc_mant_q   <= norm_ext_d[EW-1:1];
            acc_sticky_q <= norm_ext_d[0];
          end
          if (norm_ovf_d && !inf_q) begin
            inf_q      <= 1'b1;
            inf_sign_q <= sum_sign_q;
          end
        end
        S_ROUND: begin
          out_data_q  <= inf_q ? {inf_sign_q, 8'hFF, 7'h00}
                               : round_bf16(acc_sign_q, acc_exp_q, acc_mant_q, acc_sticky_q);
          out_count_q <= cnt_q;
        end
        S_OUT: begin
          if (out_ready) begin
            acc_sign_q   <= 1'b0;
            acc_exp_q    <= '0;
            acc_mant_q   <= '0;
            acc_sticky_q <= 1'b0;
            cnt_q        <= '0;
            inf_q        <= 1'b0;
            inf_sign_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfloat16_accumulator.sv
// Self-checking bench for bfloat16_accumulator: expected window results are
// queued when the last term is driven and compared when the result appears.
module tb_bfloat16_accumulator;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0]      d;
    logic [CNT_W-1:0] c;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bfloat16_accumulator #(.GUARD_BITS(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Exact bfloat16 encoding of a small integer (|n| <= 255).
  function automatic logic [15:0] int_to_bf16(input int n);
    int a, m;
    logic [7:0] e;
    logic [6:0] f;
    if (n == 0) return 16'h0000;
    a = (n < 0) ? -n : n;
    m = 0;
    for (int i = 0; i < 8; i++) if ((a >> i) != 0) m = i;
    e = 8'(127 + m);
    f = 7'((a << (7 - m)) & 'h7F);
    return {(n < 0), e, f};
  endfunction

  task automatic send_term(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_term timeout: in_ready=%b wanted 1", in_ready);
    end
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drives a 1- or 2-term window and queues the expected result.
  task automatic drive_window(input logic [15:0] a, input logic [15:0] b, input int n,
                              input logic [15:0] ed, input logic [CNT_W-1:0] ec);
    if (n == 1) begin
      sb.push_back('{d: ed, c: ec});
      send_term(a, 1'b1);
    end else begin
      send_term(a, 1'b0);
      sb.push_back('{d: ed, c: ec});
      send_term(b, 1'b1);
    end
  endtask

  // Waits (bounded) for out_valid and captures the result; out_ready is expected high.
  task automatic wait_output(output logic [15:0] d, output logic [CNT_W-1:0] c,
                             output int lat, output bit to);
    lat = 0; to = 1'b1; d = 'x; c = 'x;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        d = out_data; c = out_count; lat = i; to = 1'b0;
        break;
      end
    end
    if (!to) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset out_data: got %h want 0000", out_data); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL reset out_count: got %0d want 0", out_count); end
  endtask

  task automatic test_two_term();
    logic [15:0] od; logic [CNT_W-1:0] oc; int lat; bit to; exp_t e;
    send_term(16'h3F80, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== (k == 4)) begin errors++; $display("FAIL spacing in_ready k=%0d: got %b want %b", k, in_ready, (k == 4)); end
    end
    sb.push_back('{d: 16'h4040, c: CNT_W'(2)});
    send_term(16'h4000, 1'b1);
    wait_output(od, oc, lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != 5) begin errors++; $display("FAIL two_term latency: got %0d want 5", lat); end
    checks++; if (to || od !== e.d) begin errors++; $display("FAIL two_term data: got %h want %h", od, e.d); end
    checks++; if (to || oc !== e.c) begin errors++; $display("FAIL two_term count: got %0d want %0d", oc, e.c); end
  endtask

  // Table-driven two-term windows: cancellation, overflow, rounding, specials.
  task automatic test_pairs(input string name, input logic [15:0] ta [], input logic [15:0] tb [],
                            input int tn [], input logic [15:0] te []);
    logic [15:0] od; logic [CNT_W-1:0] oc; int lat; bit to; exp_t e;
    for (int w = 0; w < ta.size(); w++) begin
      drive_window(ta[w], tb[w], tn[w], te[w], CNT_W'(tn[w]));
      wait_output(od, oc, lat, to);
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL %s[%0d] scoreboard: got empty want entry", name, w);
      end else begin
        e = sb.pop_front();
        checks++; if (to || od !== e.d) begin errors++; $display("FAIL %s[%0d] data: got %h want %h", name, w, od, e.d); end
        checks++; if (to || oc !== e.c) begin errors++; $display("FAIL %s[%0d] count: got %0d want %0d", name, w, oc, e.c); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit got; exp_t e;
    out_ready = 1'b0;
    drive_window(16'h3F80, 16'h4000, 2, 16'h4040, CNT_W'(2));
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL bp out_valid timeout: got 0 want 1"); end
    e = sb.pop_front();
    in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp hold valid c=%0d: got %b want 1", c, out_valid); end
      checks++; if (out_data !== e.d) begin errors++; $display("FAIL bp hold data c=%0d: got %h want %h", c, out_data, e.d); end
      checks++; if (out_count !== e.c) begin errors++; $display("FAIL bp hold count c=%0d: got %0d want %0d", c, out_count, e.c); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp hold in_ready c=%0d: got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp release valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_window();
    logic [15:0] od; logic [CNT_W-1:0] oc; int lat; bit to; exp_t e; bit seen;
    send_term(16'h3F80, 1'b0);
    send_term(16'h4000, 1'b0);
    send_term(16'h4040, 1'b0);
    #3 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid: got %b want 0", out_valid); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL rst_mid out_count: got %0d want 0", out_count); end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid spurious output: got 1 want 0"); end
    drive_window(16'h4000, 16'h0000, 1, 16'h4000, CNT_W'(1));
    wait_output(od, oc, lat, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.d) begin errors++; $display("FAIL rst_mid data: got %h want %h", od, e.d); end
    checks++; if (to || oc !== e.c) begin errors++; $display("FAIL rst_mid count: got %0d want %0d", oc, e.c); end
  endtask

  task automatic test_saturation();
    logic [15:0] od; logic [CNT_W-1:0] oc; int lat; bit to; exp_t e;
    for (int i = 0; i < 301; i++) begin
      if (i == 300) sb.push_back('{d: 16'h3F80, c: {CNT_W{1'b1}}});
      send_term((i % 2 == 0) ? 16'h3F80 : 16'hBF80, (i == 300));
    end
    wait_output(od, oc, lat, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.d) begin errors++; $display("FAIL saturation data: got %h want %h", od, e.d); end
    checks++; if (to || oc !== e.c) begin errors++; $display("FAIL saturation count: got %0d want %0d", oc, e.c); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] od; logic [CNT_W-1:0] oc; int lat; bit to; exp_t e; int n, v, sum;
    for (int w = 0; w < 8; w++) begin
      n = $urandom_range(1, 8);
      sum = 0;
      for (int t = 0; t < n; t++) begin
        v = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) v = -v;
        sum += v;
        if (t == n - 1) sb.push_back('{d: int_to_bf16(sum), c: CNT_W'(n)});
        send_term(int_to_bf16(v), (t == n - 1));
      end
      wait_output(od, oc, lat, to);
      e = sb.pop_front();
      checks++; if (to || od !== e.d) begin errors++; $display("FAIL b2b[%0d] data: got %h want %h", w, od, e.d); end
      checks++; if (to || oc !== e.c) begin errors++; $display("FAIL b2b[%0d] count: got %0d want %0d", w, oc, e.c); end
    end
  endtask

  initial begin
    logic [15:0] ta [], tb [], te [];
    int tn [];
    test_reset();
    test_two_term();
    ta = '{16'h3F80, 16'hBF80}; tb = '{16'hBF80, 16'h3F80}; tn = '{2, 2}; te = '{16'h0000, 16'h0000};
    test_pairs("cancel", ta, tb, tn, te);
    ta = '{16'h7F7F, 16'h3F80}; tb = '{16'h7F7F, 16'h0000}; tn = '{2, 1}; te = '{16'h7F80, 16'h3F80};
    test_pairs("overflow", ta, tb, tn, te);
    ta = '{16'h3F80, 16'h3F81}; tb = '{16'h3B80, 16'h3B80}; tn = '{2, 2}; te = '{16'h3F80, 16'h3F82};
    test_pairs("round_tie", ta, tb, tn, te);
    ta = '{16'h0001, 16'h8000, 16'hFF80, 16'h7F80, 16'hBF80};
    tb = '{16'h0000, 16'h0000, 16'h3F80, 16'hFF80, 16'h0000};
    tn = '{1, 1, 2, 2, 1};
    te = '{16'h0000, 16'h0000, 16'hFF80, 16'h7F80, 16'hBF80};
    test_pairs("special", ta, tb, tn, te);
    test_backpressure();
    test_reset_mid_window();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

endmodule
